camera_handler: RTL and testbench
=================================

CAMERA_HANDLER -- requirements
Module: camera_handler

Interface
REQ-001 Parameter FRAME_WIDTH, default 640, pixels per captured row.
REQ-002 Parameter FRAME_HEIGHT, default 480, rows per captured frame.
REQ-003 PixelClk  input  1  camera pixel clock (PCLK); all logic on rising edge.
REQ-004 nRST  input  1  reset, asynchronous, active-low.
REQ-005 cam_vsync  input  1  camera VSYNC, active high, synchronous to PixelClk.
REQ-006 cam_href  input  1  camera HREF, high while row bytes are valid.
REQ-007 p_data  input  8  camera data byte, RGB565, high byte first.
REQ-008 init_done  input  1  PSRAM calibration complete; capture is blocked while low.
REQ-009 queue_clk  output  1  FIFO write clock, equal to PixelClk (combinational pass-through).
REQ-010 queue_data  output  17  bit16 = frame-start flag, bits15:0 = RGB565 pixel.
REQ-011 queue_wr_en  output  1  one-cycle FIFO write strobe.

Function
REQ-012 The FSM SHALL have states WAIT_CALIBRATION, WAIT_FRAME_START and ROW_CAPTURE, and SHALL leave reset in WAIT_CALIBRATION.
REQ-013 In WAIT_CALIBRATION, when init_done=1, the FSM SHALL go to WAIT_FRAME_START.
REQ-014 Frame start is a cam_vsync falling edge, detected as registered vsync=1 and current vsync=0.
REQ-015 On a frame start in WAIT_FRAME_START, the FSM SHALL go to ROW_CAPTURE with row and column counters at 0, byte phase at 0 and the first-pixel flag set.
REQ-016 In ROW_CAPTURE, when cam_href=1, bytes SHALL be sampled on every rising edge, alternating phases; phase 0 latches p_data as the high byte.
REQ-017 A phase-1 byte SHALL complete a pixel; on the next cycle the block SHALL set queue_data = {first_flag, high_byte, p_data} and queue_wr_en = 1 for exactly one cycle.
REQ-018 Latency SHALL be one PixelClk cycle from the low-byte sample edge to the queue_wr_en assertion.
REQ-019 first_flag SHALL be 1 only for pixel (0,0) of each frame and SHALL clear after that write.
REQ-020 The column counter SHALL increment per completed pixel; pixels with column >= FRAME_WIDTH SHALL be dropped (no write).
REQ-021 A cam_href falling edge SHALL increment the row counter, clear the column counter and reset the byte phase to 0.
REQ-022 A dangling odd byte at the href falling edge SHALL be discarded.
REQ-023 When the row counter reaches FRAME_HEIGHT, the FSM SHALL return to WAIT_FRAME_START; extra rows SHALL be ignored.
REQ-024 If cam_vsync rises while in ROW_CAPTURE (short frame), the FSM SHALL abort to WAIT_FRAME_START without any write.
REQ-025 If init_done drops in any state, the FSM SHALL go to WAIT_CALIBRATION on the next edge and queue_wr_en SHALL go to 0.
REQ-026 Outside ROW_CAPTURE, queue_wr_en SHALL be 0; queue_data SHALL hold its last value.
REQ-027 The block SHALL ignore FIFO full; overflow handling belongs to the consumer.
REQ-028 Counter widths SHALL be clog2(FRAME_WIDTH+1) and clog2(FRAME_HEIGHT+1).

Reset
REQ-029 While nRST=0, the block SHALL hold state = WAIT_CALIBRATION, queue_data = 0, queue_wr_en = 0, counters = 0, byte phase = 0, first_flag = 0 and the registered vsync/href = 0.
REQ-030 On reset assertion mid-frame, the block SHALL abort immediately; after release, capture SHALL restart only at a new vsync falling edge after init_done.

Structure
REQ-031 State encodings and the 17-bit queue word layout (FLAG bit 16, pixel bits 15:0) SHALL live in the shared camera_control_defs package/header.
REQ-032 The block SHALL be a single module with no sub-modules; edge detection SHALL be done inline.

Verification
REQ-033 Verify: init_done=0 with a full frame driven -> no queue_wr_en; then init_done=1 and a next frame -> capture begins.
REQ-034 Verify: a frame of 640x480 with bytes 0xAB,0xCD -> exactly 307200 writes of 0x0ABCD, with the first write = 0x1ABCD.
REQ-035 Verify: a row of 1282 bytes -> 640 writes only; a row of 7 bytes -> 3 writes, the odd byte dropped and the next row aligned.
REQ-036 Verify: vsync rising after 10 rows -> writes stop; the next frame's first write has bit16=1.
REQ-037 Verify: nRST pulsed low mid-row -> queue_wr_en=0 and queue_data=0 immediately; no writes until init_done=1 and a vsync falling edge.
REQ-038 Verify: a phase-1 byte at edge N -> queue_wr_en high at edge N+1 only, with queue_clk equal to PixelClk throughout.

Source files
------------

// File: rtl/camera_control_defs.sv
// Shared definitions for the camera capture path: FSM state encoding and the
// 17-bit word handed to the pixel FIFO.
package camera_control_defs;

    typedef enum logic [1:0] {
        WAIT_CALIBRATION = 2'd0,
        WAIT_FRAME_START = 2'd1,
        ROW_CAPTURE      = 2'd2
    } cam_state_e;

    localparam int QUEUE_WORD_W   = 17;
    localparam int QUEUE_FLAG_BIT = 16;

    // Field order puts the frame-start flag in bit 16 and RGB565 in bits 15:0.
    typedef struct packed {
        logic        frame_start;
        logic [15:0] pixel;
    } queue_word_t;

endpackage

// File: rtl/camera_handler.sv
// Captures RGB565 pixels from a DVP camera (two bytes per pixel, high byte
// first) and writes them, with a frame-start flag, into a PSRAM-bound FIFO.
module camera_handler
    import camera_control_defs::*;
#(
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 480
) (
    input  logic        PixelClk,
    input  logic        nRST,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  p_data,
    input  logic        init_done,
    output logic        queue_clk,
    output logic [16:0] queue_data,
    output logic        queue_wr_en
);

    localparam int COL_W = $clog2(FRAME_WIDTH + 1);
    localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(FRAME_WIDTH);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(FRAME_HEIGHT - 1);

    cam_state_e       state_q;
    logic             vsync_q;
    logic             href_q;
    logic             phase_q;
    logic             first_q;
    logic [7:0]       high_byte_q;
    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;
    queue_word_t      data_q;
    logic             wr_en_q;

    logic frame_start;
    logic vsync_rise;
    logic href_fall;

    assign frame_start = vsync_q & ~cam_vsync;
    assign vsync_rise  = ~vsync_q & cam_vsync;
    assign href_fall   = href_q & ~cam_href;

    assign queue_clk   = PixelClk;
    assign queue_data  = data_q;
    assign queue_wr_en = wr_en_q;

    // NOTE: every register here is written with <= so all of them see the same
    // pre-edge values; mixing in blocking writes would make the result depend
    // on statement order.
    always_ff @(posedge PixelClk or negedge nRST) begin
        if (!nRST) begin
            state_q     <= WAIT_CALIBRATION;
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            phase_q     <= 1'b0;
            first_q     <= 1'b0;
            high_byte_q <= 8'h00;
            col_q       <= '0;
            row_q       <= '0;
            data_q      <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
            wr_en_q <= 1'b0;

            if (!init_done) begin
                state_q <= WAIT_CALIBRATION;
            end else begin
                case (state_q)
                    WAIT_CALIBRATION: state_q <= WAIT_FRAME_START;

                    WAIT_FRAME_START: begin
                        if (frame_start) begin
                            state_q <= ROW_CAPTURE;
                            row_q   <= '0;
                            col_q   <= '0;
                            phase_q <= 1'b0;
                            first_q <= 1'b1;
                        end
                    end

                    ROW_CAPTURE: begin
                        if (vsync_rise) begin
                            state_q <= WAIT_FRAME_START;
                        end else if (href_fall) begin
                            // A pending odd high byte is simply forgotten here.
                            if (row_q == ROW_LAST) begin
                                state_q <= WAIT_FRAME_START;
                            end
                            row_q   <= row_q + 1'b1;
                            col_q   <= '0;
                            phase_q <= 1'b0;
                            first_q <= 1'b0;
                        end else if (cam_href) begin
                            if (!phase_q) begin
                                high_byte_q <= p_data;
                                phase_q     <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                // Columns saturate at the limit, so overlong rows drop their tail.
                                if (col_q < COL_LIMIT) begin
                                    data_q.frame_start <= first_q;
                                    data_q.pixel       <= {high_byte_q, p_data};
                                    wr_en_q            <= 1'b1;
                                    first_q            <= 1'b0;
                                    col_q              <= col_q + 1'b1;
                                end
                            end
                        end
                    end

                    default: state_q <= WAIT_CALIBRATION;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_camera_handler.sv
// Scoreboard bench for camera_handler on a reduced 8x16 frame: every write the
// stimulus intends is queued and matched against what the DUT emits.
module tb_camera_handler;

    localparam int W = 8;
    localparam int H = 16;

    logic        PixelClk = 1'b0;
    logic        nRST;
    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  p_data;
    logic        init_done;
    logic        queue_clk;
    logic [16:0] queue_data;
    logic        queue_wr_en;

    int tests_run    = 0;
    int tests_failed = 0;
    int writes       = 0;
    bit exp_first    = 1'b0;
    logic [16:0] sb[$];

    camera_handler #(.FRAME_WIDTH(W), .FRAME_HEIGHT(H)) dut (
        .PixelClk    (PixelClk),
        .nRST        (nRST),
        .cam_vsync   (cam_vsync),
        .cam_href    (cam_href),
        .p_data      (p_data),
        .init_done   (init_done),
        .queue_clk   (queue_clk),
        .queue_data  (queue_data),
        .queue_wr_en (queue_wr_en)
    );

    always #5 PixelClk = ~PixelClk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Every DUT write must match the oldest queued expectation.
    always @(posedge PixelClk) begin
        #1;
        if (queue_wr_en === 1'b1) begin
            writes++;
            if (sb.size() == 0) check("spurious_wr", 32'(queue_data), 32'h0);
            else check("wr_data", 32'(queue_data), 32'(sb.pop_front()));
        end
    end

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        repeat (3) @(negedge PixelClk);
        cam_vsync = 1'b0;
        repeat (2) @(negedge PixelClk);
    endtask

    task automatic send_row(input int nbytes, input logic [7:0] hi, input logic [7:0] lo, input bit expect_wr);
        for (int i = 0; i < nbytes; i++) begin
            cam_href = 1'b1;
            p_data   = (i % 2 == 1) ? lo : hi;
            if (i % 2 == 1 && expect_wr && (i / 2) < W) begin
                sb.push_back({exp_first, hi, lo});
                exp_first = 1'b0;
            end
            @(negedge PixelClk);
        end
        cam_href = 1'b0;
        repeat (3) @(negedge PixelClk);
    endtask

    task automatic send_frame(input int rows, input int nbytes, input logic [7:0] hi, input logic [7:0] lo, input bit expect_wr);
        vsync_pulse();
        exp_first = 1'b1;
        for (int r = 0; r < rows; r++) send_row(nbytes, hi, lo, expect_wr && r < H);
    endtask

    initial begin
        nRST = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; p_data = 8'h00; init_done = 1'b0;
        repeat (2) @(negedge PixelClk);
        #1;
        check("rst_wr_en", 32'(queue_wr_en), 32'h0);
        check("rst_data",  32'(queue_data),  32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge PixelClk); #1;
            check("qclk_high", 32'(queue_clk), 32'h1);
            @(negedge PixelClk); #1;
            check("qclk_low",  32'(queue_clk), 32'h0);
        end
        @(negedge PixelClk);
        nRST = 1'b1;
        @(negedge PixelClk);

        // Calibration pending: a whole frame must produce nothing.
        send_frame(H, 2 * W, 8'h11, 8'h22, 1'b0);
        check("nocal_writes", 32'(writes), 32'h0);
        init_done = 1'b1;
        repeat (2) @(negedge PixelClk);

        writes = 0;
        send_frame(H, 2 * W, 8'hAB, 8'hCD, 1'b1);
        check("frame1_writes", 32'(writes), 32'(W * H));

        // Rows beyond the frame height are ignored.
        writes = 0;
        send_frame(H + 2, 2 * W, 8'hAB, 8'hCD, 1'b1);
        check("extra_rows_writes", 32'(writes), 32'(W * H));

        // Overlong row, odd-length row, then realignment.
        writes = 0;
        vsync_pulse();
        exp_first = 1'b1;
        send_row(2 * W + 2, 8'h5A, 8'hA5, 1'b1);
        check("long_row_writes", 32'(writes), 32'(W));
        send_row(7, 8'h12, 8'h34, 1'b1);
        check("odd_row_writes", 32'(writes), 32'(W + 3));
        send_row(4, 8'h56, 8'h78, 1'b1);
        check("aligned_writes", 32'(writes), 32'(W + 5));

        // Short frame: vsync rises after 10 rows, later rows are not captured.
        vsync_pulse();
        exp_first = 1'b1;
        for (int r = 0; r < 10; r++) send_row(2 * W, 8'h0F, 8'hF0, 1'b1);
        cam_vsync = 1'b1;
        repeat (2) @(negedge PixelClk);
        writes = 0;
        send_row(2 * W, 8'hEE, 8'hEE, 1'b0);
        send_row(2 * W, 8'hEE, 8'hEE, 1'b0);
        check("aborted_writes", 32'(writes), 32'h0);
        send_frame(H, 2 * W, 8'h24, 8'h68, 1'b1);

        // Reset in the middle of a row.
        vsync_pulse();
        exp_first = 1'b1;
        cam_href = 1'b1;
        p_data   = 8'h9A;
        @(negedge PixelClk);
        p_data = 8'hBC;
        sb.push_back({1'b1, 8'h9A, 8'hBC});
        exp_first = 1'b0;
        @(posedge PixelClk); #1;
        check("pre_rst_wr_en", 32'(queue_wr_en), 32'h1);
        #1 nRST = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(queue_wr_en), 32'h0);
        check("mid_rst_data",  32'(queue_data),  32'h0);
        @(negedge PixelClk);
        cam_href = 1'b0;
        nRST = 1'b1;
        repeat (2) @(negedge PixelClk);
        writes = 0;
        send_row(2 * W, 8'h77, 8'h88, 1'b0);
        check("post_rst_no_writes", 32'(writes), 32'h0);
        send_frame(H, 2 * W, 8'h31, 8'h42, 1'b1);
        check("post_rst_frame_writes", 32'(writes), 32'(W * H));

        // Latency: low byte sampled at edge N, strobe seen only at edge N+1.
        vsync_pulse();
        cam_href = 1'b1;
        p_data   = 8'h3C;
        @(posedge PixelClk); #1;
        check("lat_hi_edge", 32'(queue_wr_en), 32'h0);
        @(negedge PixelClk);
        p_data = 8'hC3;
        sb.push_back({1'b1, 8'h3C, 8'hC3});
        @(posedge PixelClk); #1;
        check("lat_lo_edge", 32'(queue_wr_en), 32'h1);
        check("lat_qclk_high", 32'(queue_clk), 32'h1);
        @(negedge PixelClk); #1;
        check("lat_qclk_low", 32'(queue_clk), 32'h0);
        check("lat_hold_mid", 32'(queue_wr_en), 32'h1);
        cam_href = 1'b0;
        @(posedge PixelClk); #1;
        check("lat_one_cycle", 32'(queue_wr_en), 32'h0);
        check("lat_data_hold", 32'(queue_data), 32'h13CC3);
        repeat (3) @(negedge PixelClk);

        // Calibration lost mid-row: the completing byte must not be written.
        cam_href = 1'b1;
        p_data   = 8'h44;
        @(negedge PixelClk);
        init_done = 1'b0;
        p_data    = 8'h55;
        @(posedge PixelClk); #1;
        check("initdrop_wr_en", 32'(queue_wr_en), 32'h0);
        @(negedge PixelClk);
        cam_href  = 1'b0;
        init_done = 1'b1;
        repeat (2) @(negedge PixelClk);
        writes = 0;
        send_row(2 * W, 8'h66, 8'h99, 1'b0);
        check("initdrop_no_writes", 32'(writes), 32'h0);

        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
